spi_reg_bridge: RTL and testbench
=================================

# spi_reg_bridge

Parametrised SPI-slave-to-register bridge: the successor of the fixed 4-bit-address, 8-bit-data SPI register port used in the peripheral test harness. Accepts SPI mode 0 transactions on raw pins, synchronises them internally, and issues single-cycle read/write strobes to a peripheral register file. Adds configurable address/data width, multi-byte words and address-auto-increment bursts.

## Interface
- `ADDR_W`, 6: register address width, 1..7.
- `DATA_W`, 16: register data width, multiple of 8, 8..32.
- `SYNC_STAGES`, 2: synchroniser depth on `spi_cs_n`, `spi_clk`, `spi_mosi`, ≥2.

- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `spi_cs_n` in 1: chip select, raw pin, active-low.
- `spi_clk` in 1: SPI clock, raw pin, mode 0.
- `spi_mosi` in 1: raw pin.
- `spi_miso` out 1: serial read data, MSB first.
- `reg_addr` out ADDR_W: register address.
- `reg_wdata` out DATA_W: write data, valid with `reg_we`.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read strobe.
- `reg_rdata` in DATA_W: read data, sampled the cycle after `reg_re`.
- `busy` out 1: high while a transaction is in progress (synced CS low).

## Operation
- Command byte, MSB first: bit7 = 1 write / 0 read; bits[ADDR_W-1:0] = start address; remaining bits ignored.
- Then DATA_W/8 data bytes per word, MSB first.
- States: IDLE → CMD (CS falling edge) → WR or RD (after 8th command bit) → HOLD (word done, burst off) → IDLE (CS rising edge).
- MOSI sampled on synced SCK rising edge; MISO updated on synced SCK falling edge.
- WR: after DATA_W bits, `reg_wdata` loaded, `reg_we` pulses at `reg_addr`.
- RD: `reg_re` pulses after 8th command bit; `reg_rdata` loaded into TX shifter next cycle; MSB driven on following SCK falling edge.
- Burst: with CS held low, `reg_addr` increments by 1 after each word, wrapping 2^ADDR_W−1 → 0. For reads, `reg_re` for next address pulses after last bit of current word.
- MISO = 0 during command byte, in IDLE and HOLD.
- CS rising mid-word: partial word discarded, no strobe; state → IDLE.
- CS rising in same cycle as final bit edge: word completes, strobe issued, then IDLE.
- `reg_we` and `reg_re` never high in same cycle.

## Timing
- Reset values: `spi_miso`=0, `reg_addr`=0, `reg_wdata`=0, `reg_we`=0, `reg_re`=0, `busy`=0; state IDLE, shifters cleared.
- Input latency: pin → edge detect = SYNC_STAGES+1 clk.
- `reg_we`: 1 clk after detected rising edge of last data bit.
- `reg_re`: 1 clk after detected rising edge of last command/word bit; `reg_rdata` sampled 1 clk later.
- Requirement: f_clk ≥ 4·f_sck and SCK high/low each ≥ 2 clk.
- Reset mid-transaction: immediate return to IDLE, no strobe; bridge resumes only after a fresh CS falling edge.

## Configuration
- `SPI_REG_BRIDGE_BURST_EN` defined: auto-increment bursts as above.
- Undefined: one word per transaction; after it, state HOLD, MOSI ignored, MISO=0, no strobes until CS rises. `reg_addr` not incremented.

## Structure
- Package `spi_reg_bridge_pkg`: state enum (IDLE, CMD, WR, RD, HOLD), `CMD_W`=8, command-bit position constant `CMD_WRITE_BIT`=7.
- Sub-module: existing `synchronizer` (parameter STAGES, WIDTH=3) instantiated once for the three SPI inputs.

## Test plan
- ADDR_W=6, DATA_W=16. Write cmd 0x85, data 0xBEEF → single `reg_we`, `reg_addr`=5, `reg_wdata`=0xBEEF.
- Read cmd 0x0A, `reg_rdata`=0x1234 → `reg_re` at addr 10, MISO returns 0x1234 MSB first.
- Burst write cmd 0xBF, words 0x0001,0x0002 (burst on) → `reg_we` at addr 63 then 0 with those data; burst off → only addr 63 written.
- Burst read cmd 0x3E, regfile[62]=0xAAAA, [63]=0x5555 → MISO 0xAAAA then 0x5555, two `reg_re`.
- Write cmd 0x81, CS released after 9 data bits → no `reg_we`, `busy`=0, next transaction correct.
- `rst_n` asserted mid-read → all outputs 0 immediately; following write cmd 0x82 data 0x00FF completes normally.

Source files
------------

// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
// Holds the FSM state encoding, command byte layout and the
// bit positions of the synchronised SPI pins.
package spi_reg_bridge_pkg;

   // Bridge protocol states
   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WR,
      RD,
      HOLD
   } state_t;

   // Command byte layout
   localparam int CMD_W         = 8;
   localparam int CMD_WRITE_BIT = 7;

   // Bit counter width, large enough for a 32-bit word
   localparam int CNT_W = 6;

   // Positions of the SPI pins inside the synchroniser bus
   localparam int SYNC_CS   = 0;
   localparam int SYNC_SCK  = 1;
   localparam int SYNC_MOSI = 2;

   // Count value reached on the last bit of a field of the given width
   function automatic logic [CNT_W-1:0] last_bit(input int width);
      return CNT_W'(width - 1);
   endfunction

endpackage

// File: rtl/spi_reg_bridge_synchronizer.sv
// Multi-stage flip-flop synchroniser for asynchronous pins.
// All stages reset to zero; each stage is built by a generate loop so
// the depth follows the STAGES parameter directly.
module synchronizer #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] q_reg;
         if (gi == 0) begin : g_first
            // First stage captures the raw pins
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) q_reg <= '0;
               else        q_reg <= d;
            end
         end else begin : g_next
            // Later stages resolve metastability of the previous stage
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) q_reg <= '0;
               else        q_reg <= g_stage[gi-1].q_reg;
            end
         end
      end
   endgenerate

   assign q = g_stage[STAGES-1].q_reg;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave to register-file bridge.
// Raw SPI pins are synchronised, edge-detected and decoded into a command
// byte followed by DATA_W-bit words. Writes raise reg_we for one cycle,
// reads raise reg_re and serialise reg_rdata MSB first on spi_miso.
// Optional feature macro: SPI_REG_BRIDGE_BURST_EN enables address
// auto-increment bursts; without it a transaction carries one word.
module spi_reg_bridge
   import spi_reg_bridge_pkg::*;
#(
   parameter int ADDR_W      = 6,
   parameter int DATA_W      = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_clk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic [ADDR_W-1:0] reg_addr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              reg_we,
   output logic              reg_re,
   input  logic [DATA_W-1:0] reg_rdata,
   output logic              busy
);

`ifdef SPI_REG_BRIDGE_BURST_EN
   localparam bit BURST_EN = 1'b1;
`else
   localparam bit BURST_EN = 1'b0;
`endif

   // Synchronised pins and registered edge events
   logic [2:0] pins_sync;
   logic       cs_prev_reg;
   logic       sck_prev_reg;
   logic       cs_fall_reg;
   logic       cs_rise_reg;
   logic       sck_rise_reg;
   logic       sck_fall_reg;
   logic       mosi_smp_reg;

   // Protocol state
   state_t            state_reg,   state_next;
   logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
   logic [DATA_W-1:0] rx_reg,      rx_next;
   logic [DATA_W-1:0] tx_reg,      tx_next;
   logic              miso_reg,    miso_next;
   logic [ADDR_W-1:0] addr_reg,    addr_next;
   logic [DATA_W-1:0] wdata_reg,   wdata_next;
   logic              we_reg,      we_next;
   logic              re_reg,      re_next;
   logic              load_reg,    load_next;

   // Helpers computed in the next-state logic
   logic [DATA_W-1:0] rx_shifted;
   logic [DATA_W-1:0] tx_src;

   synchronizer #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (3)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     ({spi_mosi, spi_clk, spi_cs_n}),
      .q     (pins_sync)
   );

   // Edge detection on the synchronised pins. The chain resets to zero, so
   // a CS held low across reset never looks like a fresh falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cs_prev_reg  <= 1'b0;
         sck_prev_reg <= 1'b0;
         cs_fall_reg  <= 1'b0;
         cs_rise_reg  <= 1'b0;
         sck_rise_reg <= 1'b0;
         sck_fall_reg <= 1'b0;
         mosi_smp_reg <= 1'b0;
      end else begin
         cs_prev_reg  <= pins_sync[SYNC_CS];
         sck_prev_reg <= pins_sync[SYNC_SCK];
         cs_fall_reg  <= cs_prev_reg & ~pins_sync[SYNC_CS];
         cs_rise_reg  <= ~cs_prev_reg & pins_sync[SYNC_CS];
         sck_rise_reg <= ~sck_prev_reg & pins_sync[SYNC_SCK];
         sck_fall_reg <= sck_prev_reg & ~pins_sync[SYNC_SCK];
         // MOSI is stable around the SCK rising edge, so it is captured
         // alongside the edge event it belongs to.
         mosi_smp_reg <= pins_sync[SYNC_MOSI];
      end
   end

   // Protocol state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         rx_reg      <= '0;
         tx_reg      <= '0;
         miso_reg    <= 1'b0;
         addr_reg    <= '0;
         wdata_reg   <= '0;
         we_reg      <= 1'b0;
         re_reg      <= 1'b0;
         load_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         bit_cnt_reg <= bit_cnt_next;
         rx_reg      <= rx_next;
         tx_reg      <= tx_next;
         miso_reg    <= miso_next;
         addr_reg    <= addr_next;
         wdata_reg   <= wdata_next;
         we_reg      <= we_next;
         re_reg      <= re_next;
         load_reg    <= load_next;
      end
   end

   // Next-state, shifter and strobe logic
   always_comb begin
      state_next   = state_reg;
      bit_cnt_next = bit_cnt_reg;
      rx_next      = rx_reg;
      tx_next      = tx_reg;
      miso_next    = miso_reg;
      addr_next    = addr_reg;
      wdata_next   = wdata_reg;
      we_next      = 1'b0;
      re_next      = 1'b0;
      // Read data is taken the cycle after the read strobe
      load_next    = re_reg;

      rx_shifted = {rx_reg[DATA_W-2:0], mosi_smp_reg};
      // A falling SCK may arrive in the same cycle the read data is loaded;
      // the bypass lets the new word's MSB go straight onto MISO.
      tx_src     = load_reg ? reg_rdata : tx_reg;
      if (load_reg) tx_next = reg_rdata;

      // Write bursts step the address once the strobe has been seen
      if (BURST_EN && we_reg) addr_next = addr_reg + ADDR_W'(1);

      case (state_reg)
         IDLE: begin
            miso_next = 1'b0;
            if (cs_fall_reg) begin
               state_next   = CMD;
               bit_cnt_next = '0;
               rx_next      = '0;
               tx_next      = '0;
            end
         end

         CMD: begin
            miso_next = 1'b0;
            if (sck_rise_reg) begin
               rx_next      = rx_shifted;
               bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               if (bit_cnt_reg == last_bit(CMD_W)) begin
                  bit_cnt_next = '0;
                  addr_next    = rx_shifted[ADDR_W-1:0];
                  if (rx_shifted[CMD_WRITE_BIT]) begin
                     state_next = WR;
                  end else begin
                     state_next = RD;
                     re_next    = 1'b1;
                  end
               end
            end
         end

         WR: begin
            if (sck_rise_reg) begin
               rx_next      = rx_shifted;
               bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               if (bit_cnt_reg == last_bit(DATA_W)) begin
                  bit_cnt_next = '0;
                  wdata_next   = rx_shifted;
                  we_next      = 1'b1;
                  state_next   = BURST_EN ? WR : HOLD;
               end
            end
         end

         RD: begin
            if (sck_fall_reg) begin
               miso_next = tx_src[DATA_W-1];
               tx_next   = {tx_src[DATA_W-2:0], 1'b0};
            end
            if (sck_rise_reg) begin
               bit_cnt_next = bit_cnt_reg + CNT_W'(1);
               if (bit_cnt_reg == last_bit(DATA_W)) begin
                  bit_cnt_next = '0;
                  if (BURST_EN) begin
                     // Fetch the next word early enough for its MSB
                     addr_next = addr_reg + ADDR_W'(1);
                     re_next   = 1'b1;
                  end else begin
                     state_next = HOLD;
                     miso_next  = 1'b0;
                  end
               end
            end
         end

         HOLD: begin
            miso_next = 1'b0;
         end

         default: begin
            state_next = IDLE;
            miso_next  = 1'b0;
         end
      endcase

      // CS release ends the transaction; a word completing in the same
      // cycle has already raised its strobe above.
      if (state_reg != IDLE && cs_rise_reg) begin
         state_next   = IDLE;
         bit_cnt_next = '0;
         miso_next    = 1'b0;
      end
   end

   assign spi_miso  = miso_reg;
   assign reg_addr  = addr_reg;
   assign reg_wdata = wdata_reg;
   assign reg_we    = we_reg;
   assign reg_re    = re_reg;
   assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed testbench for spi_reg_bridge (ADDR_W=6, DATA_W=16).
// Expectations follow SPI_REG_BRIDGE_BURST_EN when it is defined.
module tb_spi_reg_bridge;

   localparam int HALF = 8;

   logic        clk;
   logic        rst_n;
   logic        spi_cs_n;
   logic        spi_clk;
   logic        spi_mosi;
   logic        spi_miso;
   logic [5:0]  reg_addr;
   logic [15:0] reg_wdata;
   logic        reg_we;
   logic        reg_re;
   logic [15:0] reg_rdata;
   logic        busy;

   spi_reg_bridge #(
      .ADDR_W      (6),
      .DATA_W      (16),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .spi_cs_n  (spi_cs_n),
      .spi_clk   (spi_clk),
      .spi_mosi  (spi_mosi),
      .spi_miso  (spi_miso),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_we    (reg_we),
      .reg_re    (reg_re),
      .reg_rdata (reg_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Peripheral register file with one cycle of read latency
   logic [15:0] mem [64];
   logic [15:0] rdata_q;
   initial rdata_q = '0;
   always @(posedge clk) if (reg_re) rdata_q <= mem[reg_addr];
   assign reg_rdata = rdata_q;

   // Strobe log
   int          we_cnt = 0;
   int          re_cnt = 0;
   int          both_cnt = 0;
   logic [5:0]  we_addr_log [64];
   logic [15:0] we_data_log [64];
   logic [5:0]  re_addr_log [64];

   always @(negedge clk) begin
      if (reg_we) begin
         if (we_cnt < 64) begin
            we_addr_log[we_cnt] = reg_addr;
            we_data_log[we_cnt] = reg_wdata;
         end
         we_cnt++;
      end
      if (reg_re) begin
         if (re_cnt < 64) re_addr_log[re_cnt] = reg_addr;
         re_cnt++;
      end
      if (reg_we && reg_re) both_cnt++;
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] tx_words [4];
   logic [15:0] rx_words [4];
   logic        busy_mid;

   // One SPI mode-0 bit: MOSI set while SCK low, MISO sampled before the rise
   task automatic spi_bit(input logic b, output logic m);
      spi_mosi = b;
      repeat (HALF) @(negedge clk);
      m = spi_miso;
      spi_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_clk = 1'b0;
   endtask

   // Full transaction: command byte then nbits data bits, then CS release
   task automatic spi_txn(input logic [7:0] cmd, input int nbits);
      logic m;
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 7; i >= 0; i--) spi_bit(cmd[i], m);
      busy_mid = busy;
      for (int i = 0; i < nbits; i++) begin
         spi_bit(tx_words[i/16][15 - (i%16)], m);
         rx_words[i/16][15 - (i%16)] = m;
      end
      repeat (HALF) @(negedge clk);
      spi_cs_n = 1'b1;
      repeat (4*HALF) @(negedge clk);
      $display("txn cmd=0x%02h data_bits=%0d rx0=0x%04h rx1=0x%04h", cmd, nbits, rx_words[0], rx_words[1]);
   endtask

   int wb;
   int rb;
   logic m_dummy;

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
      mem[10] = 16'h1234;
      mem[62] = 16'hAAAA;
      mem[63] = 16'h5555;
      for (int i = 0; i < 4; i++) begin
         tx_words[i] = '0;
         rx_words[i] = '0;
      end
      busy_mid = 1'b0;
      rst_n    = 1'b0;
      spi_cs_n = 1'b1;
      spi_clk  = 1'b0;
      spi_mosi = 1'b0;
      repeat (5) @(negedge clk);

      // Reset state
      check_val("rst_miso",  spi_miso,  0);
      check_val("rst_addr",  reg_addr,  0);
      check_val("rst_wdata", reg_wdata, 0);
      check_val("rst_we",    reg_we,    0);
      check_val("rst_re",    reg_re,    0);
      check_val("rst_busy",  busy,      0);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check_val("post_rst_busy", busy, 0);

      // Single write 0x85 / 0xBEEF
      wb = we_cnt;
      tx_words[0] = 16'hBEEF;
      spi_txn(8'h85, 16);
      check_val("wr_busy_mid", busy_mid, 1);
      check_val("wr_busy_end", busy, 0);
      check_val("wr_we_cnt", we_cnt - wb, 1);
      check_val("wr_addr", we_addr_log[wb], 5);
      check_val("wr_data", we_data_log[wb], 16'hBEEF);
`ifdef SPI_REG_BRIDGE_BURST_EN
      check_val("wr_addr_after", reg_addr, 6);
`else
      check_val("wr_addr_after", reg_addr, 5);
`endif

      // Single read 0x0A, regfile[10]=0x1234
      rb = re_cnt;
      wb = we_cnt;
      spi_txn(8'h0A, 16);
      check_val("rd_miso_word", rx_words[0], 16'h1234);
      check_val("rd_re_addr", re_addr_log[rb], 10);
`ifdef SPI_REG_BRIDGE_BURST_EN
      check_val("rd_re_cnt", re_cnt - rb, 2);
      check_val("rd_re_addr_next", re_addr_log[rb+1], 11);
`else
      check_val("rd_re_cnt", re_cnt - rb, 1);
`endif
      check_val("rd_no_we", we_cnt - wb, 0);

      // Burst write 0xBF, words 0x0001, 0x0002
      wb = we_cnt;
      tx_words[0] = 16'h0001;
      tx_words[1] = 16'h0002;
      spi_txn(8'hBF, 32);
      check_val("bw_addr0", we_addr_log[wb], 63);
      check_val("bw_data0", we_data_log[wb], 16'h0001);
`ifdef SPI_REG_BRIDGE_BURST_EN
      check_val("bw_we_cnt", we_cnt - wb, 2);
      check_val("bw_addr1", we_addr_log[wb+1], 0);
      check_val("bw_data1", we_data_log[wb+1], 16'h0002);
`else
      check_val("bw_we_cnt", we_cnt - wb, 1);
`endif

      // Burst read 0x3E, regfile[62]=0xAAAA, [63]=0x5555
      rb = re_cnt;
      tx_words[0] = 16'h0000;
      tx_words[1] = 16'h0000;
      spi_txn(8'h3E, 32);
      check_val("br_word0", rx_words[0], 16'hAAAA);
      check_val("br_re_addr0", re_addr_log[rb], 62);
`ifdef SPI_REG_BRIDGE_BURST_EN
      check_val("br_word1", rx_words[1], 16'h5555);
      check_val("br_re_addr1", re_addr_log[rb+1], 63);
`else
      check_val("br_word1", rx_words[1], 16'h0000);
      check_val("br_re_cnt", re_cnt - rb, 1);
`endif

      // Aborted write: 0x81 with only 9 data bits
      wb = we_cnt;
      tx_words[0] = 16'hFFFF;
      spi_txn(8'h81, 9);
      check_val("abort_we_cnt", we_cnt - wb, 0);
      check_val("abort_busy", busy, 0);
      tx_words[0] = 16'h1357;
      spi_txn(8'h83, 16);
      check_val("after_abort_we_cnt", we_cnt - wb, 1);
      check_val("after_abort_addr", we_addr_log[wb], 3);
      check_val("after_abort_data", we_data_log[wb], 16'h1357);

      // Reset in the middle of a read
      spi_cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int i = 7; i >= 0; i--) spi_bit(((8'h0A >> i) & 8'h01) != 0, m_dummy);
      for (int i = 0; i < 4; i++) spi_bit(1'b0, m_dummy);
      check_val("mid_rd_busy", busy, 1);
      check_val("mid_rd_addr", reg_addr, 10);
      wb = we_cnt;
      rb = re_cnt;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("mrst_miso", spi_miso, 0);
      check_val("mrst_addr", reg_addr, 0);
      check_val("mrst_busy", busy, 0);
      check_val("mrst_re", reg_re, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      // CS still low: these clocks must be ignored without a fresh CS edge
      for (int i = 0; i < 24; i++) spi_bit(1'b1, m_dummy);
      spi_cs_n = 1'b1;
      repeat (4*HALF) @(negedge clk);
      check_val("mrst_no_we", we_cnt - wb, 0);
      check_val("mrst_no_re", re_cnt - rb, 0);
      check_val("mrst_busy_after", busy, 0);
      tx_words[0] = 16'h00FF;
      spi_txn(8'h82, 16);
      check_val("mrst_wr_cnt", we_cnt - wb, 1);
      check_val("mrst_wr_addr", we_addr_log[wb], 2);
      check_val("mrst_wr_data", we_data_log[wb], 16'h00FF);

      check_val("we_re_overlap", both_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
